// File: rtl/usb_uart_in_arb_pkg.sv
// Shared definitions for the USB UART IN arbiter: FSM state encoding,
// channel header constants and the byte pipe type used on the IN path.
package usb_uart_in_arb_pkg;

    // Arbiter states: waiting for a requester, emitting the channel header,
    // and streaming data bytes from the granted source.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } arb_state_t;

    // Header byte is the base pattern with the channel number in the low nibble.
    localparam logic [7:0] HDR_BASE    = 8'hA0;
    localparam logic [7:0] HDR_ID_MASK = 8'h0F;

    // One byte lane of a valid/ready pipe.
    typedef struct packed {
        logic [7:0] data;
        logic       valid;
    } byte_pipe_t;

    // Build the channel header byte for a given owner index.
    function automatic logic [7:0] hdr_byte(input logic [7:0] id);
        return HDR_BASE | (id & HDR_ID_MASK);
    endfunction

endpackage

// File: rtl/usb_uart_in_arb_rr_pick.sv
// Combinational round-robin winner selection: the first valid index found
// searching upward from last+1, wrapping modulo N.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         valid,
    input  logic [$clog2(N)-1:0] last,
    output logic                 any,
    output logic [$clog2(N)-1:0] idx
);

    localparam int LW = $clog2(N);

    logic [LW-1:0] cand_idx [N];
    logic [N-1:0]  cand_vld;

    // Candidate gi is the requester sitting gi+1 places after the last owner.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            logic [LW:0] sum;
            assign sum          = {1'b0, last} + (LW + 1)'(gi + 1);
            assign cand_idx[gi] = (sum >= (LW + 1)'(N)) ? LW'(sum - (LW + 1)'(N))
                                                        : sum[LW-1:0];
            assign cand_vld[gi] = valid[cand_idx[gi]];
        end
    endgenerate

    // Scan from the farthest candidate down so the nearest valid one wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (cand_vld[k]) begin
                any = 1'b1;
                idx = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/usb_uart_in_arb.sv
// Round-robin arbiter merging several byte-stream sources onto the single
// USB UART IN byte path. Each grant optionally starts with a channel header
// byte and carries at most MaxBurst data bytes; data moves through the
// granted lane combinationally so bursts run at full rate.
module usb_uart_in_arb
    import usb_uart_in_arb_pkg::*;
#(
    parameter int Requesters   = 4,
    parameter int MaxBurst     = 16,
    parameter int HeaderEnable = 1
) (
    input  logic                          clk_48mhz,
    input  logic                          reset,
    input  logic [8*Requesters-1:0]       req_data,
    input  logic [Requesters-1:0]         req_valid,
    output logic [Requesters-1:0]         req_ready,
    output logic [7:0]                    uart_in_data,
    output logic                          uart_in_valid,
    input  logic                          uart_in_ready,
    output logic [$clog2(Requesters)-1:0] grant_id,
    output logic                          busy
);

    localparam int GW = $clog2(Requesters);
    localparam int CW = $clog2(MaxBurst + 1);

    arb_state_t    state_reg;
    logic [GW-1:0] grant_reg;
    logic [GW-1:0] last_grant_reg;
    logic [CW-1:0] count_reg;

    logic          pick_any;
    logic [GW-1:0] pick_idx;
    logic [7:0]    src_data [Requesters];
    byte_pipe_t    grant_pipe;
    logic          burst_last;

    // Split the flat data bus into one byte per source.
    genvar gi;
    generate
        for (gi = 0; gi < Requesters; gi++) begin : g_src
            assign src_data[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    rr_pick #(
        .N (Requesters)
    ) u_pick (
        .valid (req_valid),
        .last  (last_grant_reg),
        .any   (pick_any),
        .idx   (pick_idx)
    );

    // Lane of the current owner; only meaningful while in DATA.
    always_comb begin
        grant_pipe.data  = src_data[grant_reg];
        grant_pipe.valid = req_valid[grant_reg];
    end

    // The transfer that makes this burst reach MaxBurst bytes ends the grant.
    assign burst_last = (count_reg == CW'(MaxBurst - 1));

    // Output decode from the state; everything is held quiet while reset is high.
    always_comb begin
        uart_in_data  = 8'h00;
        uart_in_valid = 1'b0;
        req_ready     = '0;
        if (!reset) begin
            case (state_reg)
                ST_HEADER: begin
                    uart_in_data  = hdr_byte(8'(grant_reg));
                    uart_in_valid = 1'b1;
                end
                ST_DATA: begin
                    uart_in_data         = grant_pipe.data;
                    uart_in_valid        = grant_pipe.valid;
                    req_ready[grant_reg] = uart_in_ready;
                end
                default: ;
            endcase
        end
    end

    assign busy     = !reset && (state_reg != ST_IDLE);
    assign grant_id = grant_reg;

    // Arbitration FSM: pick a winner in IDLE, send its header, then stream
    // until the source runs dry or the burst limit is reached.
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            count_reg      <= '0;
            last_grant_reg <= GW'(Requesters - 1);
            grant_reg      <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_reg <= pick_idx;
                        count_reg <= '0;
                        state_reg <= (HeaderEnable != 0) ? ST_HEADER : ST_DATA;
                    end
                end
                ST_HEADER: begin
                    // Header valid is held high, so ready alone means it went out.
                    if (uart_in_ready) begin
                        state_reg <= ST_DATA;
                        count_reg <= '0;
                    end
                end
                ST_DATA: begin
                    if (!grant_pipe.valid) begin
                        // Source has nothing this cycle: give the grant back now.
                        state_reg      <= ST_IDLE;
                        last_grant_reg <= grant_reg;
                        grant_reg      <= '0;
                    end else if (uart_in_ready) begin
                        count_reg <= count_reg + CW'(1);
                        if (burst_last) begin
                            state_reg      <= ST_IDLE;
                            last_grant_reg <= grant_reg;
                            grant_reg      <= '0;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
